// File: rtl/pattern_sequencer_pkg.sv
// Shared game definitions for the pattern sequencer: FSM states, lane count,
// score/combo widths and their saturation limits.
package pattern_sequencer_pkg;
    localparam int LANES   = 4;
    localparam int SCORE_W = 16;
    localparam int COMBO_W = 8;

    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [COMBO_W-1:0] COMBO_MAX = '1;

    typedef logic [LANES-1:0] lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/pattern_sequencer_if.sv
// Game-side bus of the pattern sequencer: control, keys, next-pattern loop
// and the display/judge outputs.
interface pattern_sequencer_if
    import pattern_sequencer_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                   start;
    lane_t                  keys;
    lane_t                  next_pattern;
    lane_t                  cur_pattern;
    logic [LANES*DEPTH-1:0] rows;
    logic                   beat;
    logic                   hit;
    logic                   miss;
    logic [SCORE_W-1:0]     score;
    logic [COMBO_W-1:0]     combo;
    logic                   busy;
    logic                   done;

    modport master (
        output start, keys, next_pattern,
        input  cur_pattern, rows, beat, hit, miss, score, combo, busy, done
    );

    modport slave (
        input  start, keys, next_pattern,
        output cur_pattern, rows, beat, hit, miss, score, combo, busy, done
    );
endinterface

// File: rtl/pattern_sequencer_beat_timer.sv
// Free-running beat counter while enabled; emits a registered one-cycle pulse
// in the cycle where the count sits at BEAT_CYCLES-1.
module pattern_sequencer_beat_timer #(
    parameter int BEAT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic beat
);
    localparam int            CW   = $clog2(BEAT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(BEAT_CYCLES - 1);
    localparam logic [CW-1:0] PRE  = CW'(BEAT_CYCLES - 2);

    logic [CW-1:0] beatCnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beatCnt <= '0;
            beat    <= 1'b0;
        end else begin
            // pulse is set one count early so it lines up with beatCnt==LAST
            beat <= en && (beatCnt == PRE);
            if (!en || beatCnt == LAST) beatCnt <= '0;
            else                        beatCnt <= beatCnt + 1'b1;
        end
    end
endmodule

// File: rtl/pattern_sequencer.sv
// Beat-driven note sequencer: emits patterns into a scrolling queue and judges
// the bottom row against captured key edges on every beat.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int          DEPTH       = 8,
    parameter int          BEAT_CYCLES = 12500000,
    parameter int          NUM_BEATS   = 64,
    parameter logic [3:0]  SEED        = 4'b0001
) (
    input logic                clk,
    input logic                rst_n,
    pattern_sequencer_if.slave bus
);
    localparam int BLW = $clog2(NUM_BEATS + 1);

    state_t                     state, stateNext;
    lane_t                      curPattern, hitMask, keysQ, keyEdge, effMask;
    lane_t [DEPTH-1:0]          rowQ;
    logic [BLW-1:0]             beatsLeft;
    logic [SCORE_W-1:0]         scoreQ;
    logic [COMBO_W-1:0]         comboQ;
    logic                       hitQ, missQ, beat, playing, upperEmpty;

    assign playing    = (state == PLAY);
    assign keyEdge    = bus.keys & ~keysQ;
    assign effMask    = hitMask | keyEdge;
    assign upperEmpty = (rowQ[DEPTH-1:1] == '0);

    pattern_sequencer_beat_timer #(.BEAT_CYCLES(BEAT_CYCLES)) uTimer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (playing),
        .beat (beat)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: if (bus.start) stateNext = PLAY;
            PLAY:       if (beat && beatsLeft == '0 && upperEmpty) stateNext = DONE;
            default:    stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            curPattern <= SEED;
            rowQ       <= '0;
            beatsLeft  <= '0;
            hitMask    <= '0;
            keysQ      <= '0;
            scoreQ     <= '0;
            comboQ     <= '0;
            hitQ       <= 1'b0;
            missQ      <= 1'b0;
        end else begin
            state <= stateNext;
            keysQ <= bus.keys;
            hitQ  <= 1'b0;
            missQ <= 1'b0;
            if (!playing && bus.start) begin
                curPattern <= SEED;
                rowQ       <= '0;
                beatsLeft  <= BLW'(NUM_BEATS);
                hitMask    <= '0;
                scoreQ     <= '0;
                comboQ     <= '0;
            end else if (playing && beat) begin
                hitMask <= '0;
                // blank rows are never judged and leave combo untouched
                if (rowQ[0] != '0) begin
                    if (effMask == rowQ[0]) begin
                        hitQ   <= 1'b1;
                        scoreQ <= (scoreQ == SCORE_MAX) ? scoreQ : scoreQ + 1'b1;
                        comboQ <= (comboQ == COMBO_MAX) ? comboQ : comboQ + 1'b1;
                    end else begin
                        missQ  <= 1'b1;
                        comboQ <= '0;
                    end
                end
                for (int i = 0; i < DEPTH - 1; i++) rowQ[i] <= rowQ[i+1];
                rowQ[DEPTH-1] <= (beatsLeft != '0) ? curPattern : '0;
                curPattern    <= bus.next_pattern;
                if (beatsLeft != '0) beatsLeft <= beatsLeft - 1'b1;
            end else if (playing) begin
                hitMask <= effMask;
            end
        end
    end

    assign bus.cur_pattern = curPattern;
    assign bus.rows        = rowQ;
    assign bus.beat        = beat;
    assign bus.hit         = hitQ;
    assign bus.miss        = missQ;
    assign bus.score       = scoreQ;
    assign bus.combo       = comboQ;
    assign bus.busy        = playing;
    assign bus.done        = (state == DONE);
endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench: reset, scrolling, judging, song end/restart and combo
// saturation on two small sequencer instances.
module tb_pattern_sequencer;
    import pattern_sequencer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pattern_sequencer_if #(.DEPTH(2)) sif ();
    pattern_sequencer_if #(.DEPTH(2)) sif2 ();

    // next-pattern stubs: rotate-left for the main song, constant for the long run
    assign sif.next_pattern  = {sif.cur_pattern[2:0], sif.cur_pattern[3]};
    assign sif2.next_pattern = sif2.cur_pattern;

    pattern_sequencer #(.DEPTH(2), .BEAT_CYCLES(4), .NUM_BEATS(3), .SEED(4'b0001)) dut (
        .clk(clk), .rst_n(rst_n), .bus(sif.slave)
    );

    pattern_sequencer #(.DEPTH(2), .BEAT_CYCLES(2), .NUM_BEATS(260), .SEED(4'b0001)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(sif2.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns at the negedge inside the next beat cycle
    task automatic waitBeat(input string tag, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sif.beat && n < 20);
        checks++;
        assert (sif.beat === 1'b1) else begin
            errors++;
            $error("FAIL %s observed no beat expected beat within 20 cycles", tag);
        end
        at = cyc;
    endtask

    initial begin
        int  t1, t2, tb, n;
        bit  saw;
        sif.start  = 1'b0; sif.keys  = '0;
        sif2.start = 1'b0; sif2.keys = '0;

        #12;
        chk("rst_cur", sif.cur_pattern, 4'b0001);
        chk("rst_rows", sif.rows, 8'h00);
        chk("rst_flags", {sif.beat, sif.hit, sif.miss, sif.busy, sif.done}, 5'b0);
        chk("rst_score", sif.score, 16'h0);

        // reset asserted mid-count
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        chk("pre_rst_busy", sif.busy, 1'b1);
        @(negedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_busy", sif.busy, 1'b0);
        chk("midrst_cur", sif.cur_pattern, 4'b0001);
        saw = 1'b0;
        repeat (8) @(negedge clk) if (sif.beat || sif.hit || sif.miss) saw = 1'b1;
        chk("midrst_no_pulse", saw, 1'b0);
        rst_n = 1'b1;

        // song 1: scrolling and judging
        @(negedge clk) sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        chk("s1_busy", sif.busy, 1'b1);
        waitBeat("s1_b1", t1);
        @(negedge clk);
        chk("s1_b1_rows", sif.rows, 8'h10);
        chk("s1_b1_cur", sif.cur_pattern, 4'b0010);
        waitBeat("s1_b2", t2);
        chk("s1_spacing", t2 - t1, 4);
        @(negedge clk);
        chk("s1_b2_rows", sif.rows, 8'h21);
        chk("s1_b2_nojudge", {sif.hit, sif.miss}, 2'b00);
        sif.keys = 4'b0001;
        @(negedge clk) sif.keys = 4'b0000;
        waitBeat("s1_b3", tb);
        @(negedge clk);
        chk("s1_b3_hitmiss", {sif.hit, sif.miss}, 2'b10);
        chk("s1_b3_score", sif.score, 16'd1);
        chk("s1_b3_combo", sif.combo, 8'd1);
        chk("s1_b3_rows", sif.rows, 8'h42);
        sif.start = 1'b1;
        sif.keys  = 4'b0110;
        @(negedge clk);
        sif.start = 1'b0;
        sif.keys  = 4'b0000;
        waitBeat("s1_b4", tb);
        @(negedge clk);
        chk("s1_b4_hitmiss", {sif.hit, sif.miss}, 2'b01);
        chk("s1_b4_combo", sif.combo, 8'd0);
        chk("s1_b4_score_kept", sif.score, 16'd1);
        chk("s1_b4_rows", sif.rows, 8'h04);
        chk("s1_b4_busy", sif.busy, 1'b1);
        sif.keys = 4'b0100;
        @(negedge clk) sif.keys = 4'b0000;
        waitBeat("s1_b5", tb);
        @(negedge clk);
        chk("s1_b5_hit", sif.hit, 1'b1);
        chk("s1_b5_score", sif.score, 16'd2);
        chk("s1_b5_done_busy", {sif.done, sif.busy}, 2'b10);
        chk("s1_b5_rows", sif.rows, 8'h00);
        saw = 1'b0;
        repeat (12) @(negedge clk) if (sif.beat) saw = 1'b1;
        chk("s1_no_extra_beat", saw, 1'b0);
        chk("s1_done_score_hold", sif.score, 16'd2);

        // song 2: restart from DONE, held key and beat-cycle press
        sif.start = 1'b1;
        @(negedge clk) sif.start = 1'b0;
        chk("s2_score_clr", sif.score, 16'd0);
        chk("s2_state", {sif.done, sif.busy}, 2'b01);
        chk("s2_cur", sif.cur_pattern, 4'b0001);
        waitBeat("s2_b1", tb);
        waitBeat("s2_b2", tb);
        @(negedge clk) sif.keys = 4'b0010;
        waitBeat("s2_b3", tb);
        @(negedge clk);
        chk("s2_b3_wrong_key", {sif.hit, sif.miss}, 2'b01);
        waitBeat("s2_b4", tb);
        @(negedge clk);
        chk("s2_b4_held_key", {sif.hit, sif.miss}, 2'b01);
        chk("s2_b4_score", sif.score, 16'd0);
        sif.keys = 4'b0000;
        waitBeat("s2_b5", tb);
        sif.keys = 4'b0100;
        @(negedge clk);
        sif.keys = 4'b0000;
        chk("s2_b5_same_cycle", {sif.hit, sif.miss}, 2'b10);
        chk("s2_b5_score", sif.score, 16'd1);
        chk("s2_b5_done", sif.done, 1'b1);

        // long run: 260 consecutive hits saturate combo
        @(negedge clk) sif2.start = 1'b1;
        @(negedge clk) sif2.start = 1'b0;
        n = 0;
        while (!sif2.done && n < 1000) begin
            @(negedge clk);
            sif2.keys = sif2.beat ? 4'b0000 : 4'b0001;
            n++;
        end
        sif2.keys = 4'b0000;
        chk("sat_done", sif2.done, 1'b1);
        chk("sat_combo", sif2.combo, 8'd255);
        chk("sat_score", sif2.score, 16'd260);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
